// File: rtl/hps_fpga_mem_pkg.sv
// Shared constants, mode encodings and controller states for the RAM test master.
package hps_fpga_mem_pkg;

  localparam int MEM_ADDR_W    = 13;
  localparam int MEM_DATA_W    = 64;
  localparam int MEM_BE_W      = MEM_DATA_W / 8;
  localparam int MEM_MAX_WORDS = 8192;

  typedef enum logic [1:0] {
    MODE_FILL       = 2'd0,
    MODE_CHECK      = 2'd1,
    MODE_FILL_CHECK = 2'd2,
    MODE_RSVD       = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/hps_fpga_mem_pattern_gen.sv
// Word index counter producing the registered bus address and pattern P(i) = seed + i.
// load restarts at index 0, advance steps to the next word; base/seed are held by the caller.
module hps_fpga_mem_pattern_gen
  import hps_fpga_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W:0]   idx,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pattern
);

  logic [ADDR_W:0] idx_next;

  // Index that the next load/advance will present on the bus.
  always_comb begin
    idx_next = load ? '0 : idx + 1'b1;
  end

  // Address wraps naturally at 2^ADDR_W; pattern wraps at 2^DATA_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx     <= '0;
      addr    <= '0;
      pattern <= '0;
    end else if (load || advance) begin
      idx     <= idx_next;
      addr    <= base + idx_next[ADDR_W-1:0];
      pattern <= seed + DATA_W'(idx_next);
    end
  end

endmodule

// File: rtl/hps_fpga_mem_test_master.sv
// Avalon-MM fill/check engine for the on-chip RAM second port.
//
// state    | meaning
// ST_IDLE  | waiting for start, results held
// ST_WRITE | one pattern write per cycle
// ST_READ  | one read per cycle, data compared one cycle later
// ST_DRAIN | no access, last read word is compared
// ST_DONE  | one-cycle done pulse
module hps_fpga_mem_test_master
  import hps_fpga_mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int BE_W      = MEM_BE_W,
  parameter int MAX_WORDS = MEM_MAX_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] address,
  output logic [BE_W-1:0]   byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata
);

  localparam logic [ADDR_W:0] MAX_N = (ADDR_W + 1)'(MAX_WORDS);

  state_e            state, state_next;
  logic [1:0]        mode_l;
  logic [ADDR_W-1:0] base_l;
  logic [DATA_W-1:0] seed_l;
  logic [ADDR_W:0]   n_l;
  logic [ADDR_W:0]   n_in;
  logic              accept;
  logic              last;
  logic              pg_load;
  logic              pg_advance;
  logic [ADDR_W-1:0] pg_base;
  logic [DATA_W-1:0] pg_seed;
  logic [ADDR_W:0]   idx;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  // Clamp the request, and steer base/seed straight from the inputs on the accepting edge.
  always_comb begin
    n_in    = (word_count > MAX_N) ? MAX_N : word_count;
    accept  = (state == ST_IDLE) && start;
    last    = (idx == n_l - 1'b1);
    pg_base = accept ? base_addr : base_l;
    pg_seed = accept ? seed : seed_l;
  end

  hps_fpga_mem_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pg_load),
    .advance (pg_advance),
    .base    (pg_base),
    .seed    (pg_seed),
    .idx     (idx),
    .addr    (address),
    .pattern (writedata)
  );

  // Next state plus pattern generator load/advance; the WRITE->READ hop rewinds to word 0.
  always_comb begin
    state_next = state;
    pg_load    = 1'b0;
    pg_advance = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          pg_load = 1'b1;
          if (n_in == '0)              state_next = ST_DONE;
          else if (mode == MODE_CHECK) state_next = ST_READ;
          else                         state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (last) begin
          if (mode_l != MODE_FILL) begin
            state_next = ST_READ;
            pg_load    = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          pg_advance = 1'b1;
        end
      end
      ST_READ: begin
        if (last) state_next = ST_DRAIN;
        else      pg_advance = 1'b1;
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register and run parameters captured on the accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      mode_l <= '0;
      base_l <= '0;
      seed_l <= '0;
      n_l    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mode_l <= mode;
        base_l <= base_addr;
        seed_l <= seed;
        n_l    <= n_in;
      end
    end
  end

  // Registered bus strobes and status, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chipselect <= 1'b0;
      write      <= 1'b0;
      byteenable <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      chipselect <= (state_next == ST_WRITE) || (state_next == ST_READ);
      write      <= (state_next == ST_WRITE);
      byteenable <= ((state_next == ST_WRITE) || (state_next == ST_READ)) ? '1 : '0;
      busy       <= (state_next != ST_IDLE);
      done       <= (state_next == ST_DONE);
    end
  end

  // Carry expected word and address alongside the read so they meet readdata one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
    end else begin
      cmp_valid <= (state == ST_READ);
      cmp_exp   <= writedata;
      cmp_addr  <= address;
    end
  end

  // Error capture; cleared on start, held afterwards. Count cannot exceed MAX_WORDS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
      error          <= 1'b0;
    end else if (accept) begin
      err_count      <= '0;
      first_err_addr <= '0;
      error          <= 1'b0;
    end else if (cmp_valid && (readdata != cmp_exp)) begin
      err_count <= err_count + 1'b1;
      error     <= 1'b1;
      if (err_count == '0) first_err_addr <= cmp_addr;
    end
  end

endmodule

// File: tb/tb_hps_fpga_mem_test_master.sv
// Scoreboard bench: each run pushes its expected bus accesses and completion result,
// a monitor pops and compares whenever the DUT accesses the RAM model or pulses done.
module tb_hps_fpga_mem_test_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic [12:0] base_addr;
  logic [13:0] word_count;
  logic [63:0] seed;
  logic        busy, done, error;
  logic [13:0] err_count;
  logic [12:0] first_err_addr;
  logic [12:0] address;
  logic [7:0]  byteenable;
  logic        chipselect, write;
  logic [63:0] writedata;
  logic [63:0] readdata;

  always #5 clk = ~clk;

  hps_fpga_mem_test_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .mode           (mode),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .address        (address),
    .byteenable     (byteenable),
    .chipselect     (chipselect),
    .write          (write),
    .writedata      (writedata),
    .readdata       (readdata)
  );

  // RAM slave model, read latency 1, with a backdoor write port.
  logic [63:0] ram [0:8191];
  logic        bd_en = 1'b0;
  logic [12:0] bd_addr = '0;
  logic [63:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_en) ram[bd_addr] <= bd_data;
    if (chipselect) begin
      if (write) ram[address] <= writedata;
      else       readdata <= ram[address];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [12:0] addr;
    logic        wr;
    logic [63:0] data;
    int          cyc;
  } acc_t;

  typedef struct {
    logic [13:0] cnt;
    logic [12:0] first;
    int          cyc;
  } res_t;

  acc_t        acc_q[$];
  res_t        res_q[$];
  acc_t        ea;
  res_t        er;
  int          checks = 0;
  int          errors = 0;
  logic [13:0] exp_cnt;
  logic [12:0] exp_first;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (chipselect) begin
          checks++;
          if (acc_q.size() == 0) begin
            errors++;
            $display("FAIL access: got unexpected access addr=%h wr=%b at cycle %0d, required none",
                     address, write, cyc);
          end else begin
            ea = acc_q.pop_front();
            if (address !== ea.addr || write !== ea.wr || (ea.wr && writedata !== ea.data) ||
                byteenable !== 8'hFF || busy !== 1'b1 || cyc != ea.cyc) begin
              errors++;
              $display("FAIL access: got addr=%h wr=%b data=%h be=%h busy=%b cyc=%0d, required addr=%h wr=%b data=%h be=ff busy=1 cyc=%0d",
                       address, write, writedata, byteenable, busy, cyc,
                       ea.addr, ea.wr, ea.data, ea.cyc);
            end
          end
        end
        if (done) begin
          checks++;
          if (res_q.size() == 0) begin
            errors++;
            $display("FAIL done: got unexpected done at cycle %0d, required none", cyc);
          end else begin
            er = res_q.pop_front();
            if (err_count !== er.cnt || first_err_addr !== er.first ||
                error !== (er.cnt != 0) || busy !== 1'b1 || cyc != er.cyc) begin
              errors++;
              $display("FAIL done: got cnt=%0d first=%h error=%b busy=%b cyc=%0d, required cnt=%0d first=%h error=%b busy=1 cyc=%0d",
                       err_count, first_err_addr, error, busy, cyc,
                       er.cnt, er.first, (er.cnt != 0), er.cyc);
            end
          end
        end
      end
    end
  endtask

  // Reference model: word i goes to (b+i) mod 8192 with data s+i; a CHECK counts words
  // that differ in the RAM at issue time. Called at posedge+1 with the DUT idle.
  task automatic issue(input logic [1:0] m, input logic [12:0] b, input logic [13:0] wc,
                       input logic [63:0] s);
    int          n;
    int          c;
    int          e0;
    logic [12:0] a;
    res_t        r;
    n = (wc > 14'd8192) ? 8192 : int'(wc);
    start = 1'b1; mode = m; base_addr = b; word_count = wc; seed = s;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
    mode = 2'($urandom); base_addr = 13'($urandom); word_count = 14'($urandom);
    seed = {$urandom, $urandom};
    r.cnt = '0; r.first = '0;
    c = 1;
    if (n > 0) begin
      if (m != 2'd1) begin
        for (int i = 0; i < n; i++) begin
          acc_q.push_back('{addr: 13'(b + 13'(i)), wr: 1'b1, data: s + 64'(i), cyc: e0 + c - 1});
          c++;
        end
      end
      if (m != 2'd0) begin
        for (int i = 0; i < n; i++) begin
          a = 13'(b + 13'(i));
          if (m == 2'd1 && ram[a] !== s + 64'(i)) begin
            if (r.cnt == 0) r.first = a;
            r.cnt++;
          end
          acc_q.push_back('{addr: a, wr: 1'b0, data: 64'h0, cyc: e0 + c - 1});
          c++;
        end
        c++;
      end
    end
    r.cyc = e0 + c - 1;
    res_q.push_back(r);
    exp_cnt = r.cnt;
    exp_first = r.first;
  endtask

  task automatic wait_done(input int budget, input int poke);
    for (int k = 0; k < budget; k++) begin
      if (res_q.size() == 0) break;
      if (k == poke) begin
        start = 1'b1; mode = 2'($urandom); base_addr = 13'($urandom);
        word_count = 14'($urandom_range(1, 20));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (res_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: got no done within %0d cycles, required done", budget);
    end
    checks++;
    if (acc_q.size() != 0) begin
      errors++;
      $display("FAIL missing_access: got %0d accesses not issued, required 0", acc_q.size());
    end
    res_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    chk("hold_err_count", 64'(err_count), 64'(exp_cnt));
    chk("hold_first_err_addr", 64'(first_err_addr), 64'(exp_first));
    chk("hold_error_busy", {62'd0, error, busy}, {62'd0, (exp_cnt != 0), 1'b0});
  endtask

  task automatic run(input logic [1:0] m, input logic [12:0] b, input logic [13:0] wc,
                     input logic [63:0] s, input int poke);
    issue(m, b, wc, s);
    wait_done(2 * 8192 + 10, poke);
  endtask

  task automatic corrupt(input logic [12:0] a, input logic [63:0] d);
    bd_addr = a; bd_data = d; bd_en = 1'b1;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  initial begin
    logic [1:0]  m;
    logic [12:0] b;
    logic [13:0] wc;
    logic [63:0] s;
    logic [63:0] s2;
    reset_n = 1'b0; start = 1'b0; mode = '0; base_addr = '0; word_count = '0; seed = '0;
    fork
      monitor();
      begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk); #1;
    chk("reset_ctrl", {51'd0, busy, done, error, chipselect, write, byteenable}, 64'd0);
    chk("reset_address", 64'(address), 64'd0);
    chk("reset_writedata", writedata, 64'd0);
    chk("reset_err", {37'd0, err_count, first_err_addr}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run(2'd0, 13'h0100, 14'd4, 64'h0, -1);
    run(2'd2, 13'h1FFE, 14'd4, 64'hFFFF_FFFF_FFFF_FFFF, -1);
    corrupt(13'h0000, 64'hDEAD_BEEF_0000_0000);
    corrupt(13'h0001, 64'h0000_0000_0000_0007);
    run(2'd1, 13'h1FFE, 14'd4, 64'hFFFF_FFFF_FFFF_FFFF, -1);
    chk("inject_err_count", 64'(err_count), 64'd2);
    chk("inject_first_err_addr", 64'(first_err_addr), 64'h0);
    chk("inject_error", 64'(error), 64'd1);

    run(2'd1, 13'h0444, 14'd0, 64'h5, -1);
    run(2'd3, 13'h0005, 14'd3, 64'h1234, -1);
    run(2'd0, 13'h0A00, 14'd6, 64'h55, 2);

    issue(2'd1, 13'h0100, 14'd20, 64'h9);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset_ctrl", {51'd0, busy, done, error, chipselect, write, byteenable}, 64'd0);
    chk("midreset_address", 64'(address), 64'd0);
    chk("midreset_writedata", writedata, 64'd0);
    chk("midreset_err", {37'd0, err_count, first_err_addr}, 64'd0);
    acc_q.delete();
    res_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run(2'd2, 13'h0200, 14'd5, 64'hA5A5_0000_1111_2222, -1);

    for (int it = 0; it < 40; it++) begin
      m  = 2'($urandom_range(0, 3));
      b  = 13'($urandom);
      wc = 14'($urandom_range(0, 40));
      s  = {$urandom, $urandom};
      if (m == 2'd1) begin
        run(2'd0, b, wc, s, -1);
        if (wc != 0) begin
          for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            logic [12:0] ca;
            ca = 13'(b + 13'($urandom_range(0, int'(wc) - 1)));
            corrupt(ca, ram[ca] ^ {32'h0, $urandom | 32'h1});
          end
        end
        s2 = ($urandom_range(0, 3) == 0) ? (s ^ 64'h10) : s;
        run(2'd1, b, wc, s2, -1);
      end else begin
        run(m, b, wc, s, -1);
      end
    end

    run(2'd0, 13'h0123, 14'h3FFF, {$urandom, $urandom}, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
